// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: instruction width, RV32I NOP encoding (driven on inst_data while
// the buffer is empty), default reset PC and a clog2 helper for sizing.
package fetch_unit_pkg;

   localparam int               INST_W           = 32;
   localparam logic [INST_W-1:0] NOP_INST        = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [31:0]      DEFAULT_RESET_PC = 32'h0000_0000;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the fetch front end's imem, decode and redirect signals.
// Latency: n/a (wiring only).
// Backpressure: decode stalls fetch through inst_ready; fetch_en halts issue.
//
// Modports: master = fetch unit, slave = surrounding core (imem, decode, execute).
interface fetch_unit_if #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 4
);
   import fetch_unit_pkg::*;

   localparam int CW = clog2(FIFO_DEPTH) + 1;

   logic              fetch_en;
   logic              imem_req;
   logic [XLEN-1:0]   imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] inst_data;
   logic [XLEN-1:0]   inst_pc;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic [CW-1:0]     fifo_count;

   modport master (
      input  fetch_en,
      output imem_req, imem_addr,
      input  imem_rdata,
      output inst_valid, inst_data, inst_pc,
      input  inst_ready,
      input  redirect_valid, redirect_pc,
      output fifo_count
   );

   modport slave (
      output fetch_en,
      input  imem_req, imem_addr,
      output imem_rdata,
      input  inst_valid, inst_data, inst_pc,
      output inst_ready,
      output redirect_valid, redirect_pc,
      input  fifo_count
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// First-word-fall-through FIFO with synchronous clear (module sync_fifo_fwft).
// Latency: push at edge t is visible on o_head / o_count right after edge t.
// Backpressure: none internally; the writer must never push into a full FIFO.
//
// Ports: clock, reset (async, high), i_clear (sync flush, beats push/pop),
//        i_push/i_push_dat, i_pop, o_head (entry at read pointer), o_count.
module sync_fifo_fwft
   import fetch_unit_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_clear,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [clog2(DEPTH):0]    o_count
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   wire w_do_push = i_push & ~i_clear;
   wire w_do_pop  = i_pop & (r_count != '0) & ~i_clear;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // Storage carries no reset: o_head is only meaningful while r_count != 0.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wptr] <= i_push_dat;
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(w_do_push && !w_do_pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns fetch PC, issues imem reads, buffers {pc,inst}.
// Latency: request at cycle t -> inst_valid at t+2; redirect at t -> target valid at t+3.
// Backpressure: inst_ready=0 holds the head; issue stops once buffer + in-flight reach FIFO_DEPTH.
//
// Ports: clock, reset (async, high); io (fetch_unit_if.master):
//   fetch_en, imem_req/imem_addr/imem_rdata, inst_valid/inst_ready/inst_data/inst_pc,
//   redirect_valid/redirect_pc, fifo_count.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter int              ADDR_STEP  = 1,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
   parameter int              FIFO_DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master io
);

   localparam int CW = clog2(FIFO_DEPTH) + 1;
   localparam int EW = XLEN + INST_W;

   logic [XLEN-1:0] r_fpc;
   logic            r_ifl;
   logic [XLEN-1:0] r_ifl_pc;

   logic [EW-1:0]   w_head;
   logic [CW-1:0]   w_count;
   logic            w_valid;
   logic            w_credit;
   logic            w_req;
   logic            w_push;
   logic            w_pop;

   // Credit: every buffered entry plus the one in flight has a reserved slot,
   // so a returning word can always be pushed.
   assign w_credit = ({1'b0, w_count} + (CW+1)'(r_ifl)) < (CW+1)'(FIFO_DEPTH);
   assign w_req    = ~reset & io.fetch_en & ~io.redirect_valid & w_credit;
   assign w_push   = r_ifl & ~io.redirect_valid;
   assign w_valid  = (w_count != '0);
   assign w_pop    = w_valid & io.inst_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fpc    <= RESET_PC;
         r_ifl    <= 1'b0;
         r_ifl_pc <= '0;
      end else if (io.redirect_valid) begin
         // Redirect wins: the word returning this cycle is stale and is dropped.
         r_fpc <= io.redirect_pc;
         r_ifl <= 1'b0;
      end else if (w_req) begin
         r_fpc    <= r_fpc + XLEN'(ADDR_STEP);
         r_ifl    <= 1'b1;
         r_ifl_pc <= r_fpc;
      end else begin
         r_ifl <= 1'b0;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_clear    (io.redirect_valid),
      .i_push     (w_push),
      .i_push_dat ({r_ifl_pc, io.imem_rdata}),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_count    (w_count)
   );

   assign io.imem_req   = w_req;
   assign io.imem_addr  = r_fpc;
   assign io.inst_valid = w_valid;
   assign io.fifo_count = w_count;
   assign io.inst_pc    = w_valid ? w_head[EW-1:INST_W] : '0;
   // Empty buffer shows a NOP to decode, but all-zero while reset is held.
   assign io.inst_data  = w_valid ? w_head[INST_W-1:0] : (reset ? '0 : NOP_INST);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus queues expected PCs,
// a negedge monitor pops and compares every accepted instruction.
// The imem model returns ~address as the instruction word.
module tb_fetch_unit;

   logic clock;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pop    = 0;

   logic [31:0] exp_q[$];

   fetch_unit_if #(.XLEN(32), .FIFO_DEPTH(4)) io  ();
   fetch_unit_if #(.XLEN(32), .FIFO_DEPTH(4)) io4 ();

   fetch_unit #(
      .XLEN(32), .ADDR_STEP(1), .RESET_PC(32'h0), .FIFO_DEPTH(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   fetch_unit #(
      .XLEN(32), .ADDR_STEP(4), .RESET_PC(32'h100), .FIFO_DEPTH(4)
   ) dut4 (
      .clock (clock),
      .reset (reset),
      .io    (io4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous imem, 1-cycle read latency.
   always @(posedge clock) begin
      if (io.imem_req)  io.imem_rdata  <= ~io.imem_addr;
      if (io4.imem_req) io4.imem_rdata <= ~io4.imem_addr;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_stream(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
   endtask

   task automatic wait_pops(input int n, input string name);
      int start;
      int k;
      start = n_pop;
      k = 0;
      while (n_pop < start + n && k < 200) begin
         @(negedge clock);
         #1;
         k++;
      end
      n_checks++;
      if (n_pop < start + n) begin
         n_fail++;
         $display("FAIL %s: popped %0d required %0d", name, n_pop - start, n);
      end
   endtask

   task automatic wait_count(input int v, input string name);
      int k;
      k = 0;
      while (int'(io.fifo_count) != v && k < 50) begin
         @(negedge clock);
         k++;
      end
      n_checks++;
      if (int'(io.fifo_count) != v) begin
         n_fail++;
         $display("FAIL %s: fifo_count %0d required %0d", name, io.fifo_count, v);
      end
   endtask

   // Monitor: every accepted, non-voided handshake is checked in order.
   always @(negedge clock) begin
      logic [31:0] e_pc;
      logic [31:0] e_dat;
      if (!reset && io.inst_valid && io.inst_ready && !io.redirect_valid) begin
         n_pop++;
         if (exp_q.size() != 0) begin
            e_pc  = exp_q.pop_front();
            e_dat = ~e_pc;
            chk("stream_pc",   64'(io.inst_pc),   64'(e_pc));
            chk("stream_data", 64'(io.inst_data), 64'(e_dat));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset              = 1'b1;
      io.fetch_en        = 1'b1;
      io.inst_ready      = 1'b0;
      io.redirect_valid  = 1'b0;
      io.redirect_pc     = '0;
      io4.fetch_en       = 1'b1;
      io4.inst_ready     = 1'b1;
      io4.redirect_valid = 1'b0;
      io4.redirect_pc    = '0;

      // Reset state, with fetch_en already high.
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_req",    64'(io.imem_req),   64'(0));
      chk("rst_valid",  64'(io.inst_valid), 64'(0));
      chk("rst_count",  64'(io.fifo_count), 64'(0));
      chk("rst_data",   64'(io.inst_data),  64'(0));
      chk("rst_pc",     64'(io.inst_pc),    64'(0));
      chk("rst_addr",   64'(io.imem_addr),  64'(0));
      chk("rst_addr4",  64'(io4.imem_addr), 64'h100);
      chk("rst_req4",   64'(io4.imem_req),  64'(0));

      // 1: streaming from RESET_PC, one per cycle, valid from cycle 2.
      @(posedge clock); #1;
      reset = 1'b0;
      io.inst_ready = 1'b1;
      push_stream(32'h0, 200);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("t1_addr",  64'(io.imem_addr),  64'(i));
         chk("t1_req",   64'(io.imem_req),   64'(1));
         chk("t1_valid", 64'(io.inst_valid), 64'(i >= 2));
         if (i >= 2) chk("t1_pc", 64'(io.inst_pc), 64'(i - 2));
      end

      // 2: stall decode, buffer saturates, then drain in order.
      @(posedge clock); #1;
      io.inst_ready = 1'b0;
      repeat (10) @(negedge clock);
      chk("t2_count_sat", 64'(io.fifo_count), 64'(4));
      chk("t2_req_off",   64'(io.imem_req),   64'(0));
      chk("t2_valid",     64'(io.inst_valid), 64'(1));
      @(posedge clock); #1;
      io.inst_ready = 1'b1;
      wait_pops(12, "t2_drain");

      // 3: redirect to 0x40 with three buffered plus one in flight.
      @(posedge clock); #1;
      io.inst_ready = 1'b0;
      wait_count(3, "t3_fill");
      io.redirect_valid = 1'b1;
      io.redirect_pc    = 32'h40;
      exp_q.delete();
      push_stream(32'h40, 200);
      #1;
      chk("t3_req_in_redirect", 64'(io.imem_req), 64'(0));
      @(posedge clock); #1;
      io.redirect_valid = 1'b0;
      io.inst_ready     = 1'b1;
      @(negedge clock);
      chk("t3_count_flushed", 64'(io.fifo_count), 64'(0));
      chk("t3_valid_t1",      64'(io.inst_valid), 64'(0));
      chk("t3_req_t1",        64'(io.imem_req),   64'(1));
      chk("t3_addr_t1",       64'(io.imem_addr),  64'h40);
      @(negedge clock);
      chk("t3_valid_t2",      64'(io.inst_valid), 64'(0));
      @(negedge clock);
      chk("t3_valid_t3",      64'(io.inst_valid), 64'(1));
      chk("t3_pc_t3",         64'(io.inst_pc),    64'h40);
      wait_pops(6, "t3_stream");

      // 4: back-to-back redirects, the second wins.
      @(posedge clock); #1;
      io.redirect_valid = 1'b1;
      io.redirect_pc    = 32'h10;
      exp_q.delete();
      @(posedge clock); #1;
      io.redirect_pc    = 32'h20;
      exp_q.delete();
      push_stream(32'h20, 200);
      @(posedge clock); #1;
      io.redirect_valid = 1'b0;
      @(negedge clock);
      chk("t4_addr",  64'(io.imem_addr),  64'h20);
      chk("t4_req",   64'(io.imem_req),   64'(1));
      chk("t4_count", 64'(io.fifo_count), 64'(0));
      wait_pops(6, "t4_stream");

      // 5: ADDR_STEP=4 instance wraps at the top of the address space.
      @(posedge clock); #1;
      io4.redirect_valid = 1'b1;
      io4.redirect_pc    = 32'hFFFF_FFFC;
      @(posedge clock); #1;
      io4.redirect_valid = 1'b0;
      @(negedge clock);
      chk("t5_addr_top",  64'(io4.imem_addr),  64'hFFFF_FFFC);
      @(negedge clock);
      chk("t5_addr_wrap", 64'(io4.imem_addr),  64'h0);
      @(negedge clock);
      chk("t5_addr_4",    64'(io4.imem_addr),  64'h4);
      chk("t5_valid",     64'(io4.inst_valid), 64'(1));
      chk("t5_pc_top",    64'(io4.inst_pc),    64'hFFFF_FFFC);
      chk("t5_data_top",  64'(io4.inst_data),  64'h3);
      @(negedge clock);
      chk("t5_pc_wrap",   64'(io4.inst_pc),    64'h0);
      chk("t5_data_wrap", 64'(io4.inst_data),  64'hFFFF_FFFF);

      // 6: async reset mid-operation, then restart at RESET_PC.
      @(posedge clock); #1;
      io.inst_ready = 1'b0;
      wait_count(3, "t6_fill");
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("t6_req",   64'(io.imem_req),   64'(0));
      chk("t6_valid", 64'(io.inst_valid), 64'(0));
      chk("t6_count", 64'(io.fifo_count), 64'(0));
      chk("t6_data",  64'(io.inst_data),  64'(0));
      chk("t6_pc",    64'(io.inst_pc),    64'(0));
      chk("t6_addr",  64'(io.imem_addr),  64'(0));
      chk("t6_addr4", 64'(io4.imem_addr), 64'h100);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      io.inst_ready = 1'b1;
      push_stream(32'h0, 200);
      @(negedge clock);
      chk("t6_restart_addr0", 64'(io.imem_addr),  64'(0));
      chk("t6_restart_req",   64'(io.imem_req),   64'(1));
      @(negedge clock);
      chk("t6_restart_addr1", 64'(io.imem_addr),  64'(1));
      @(negedge clock);
      chk("t6_restart_valid", 64'(io.inst_valid), 64'(1));
      chk("t6_restart_pc",    64'(io.inst_pc),    64'(0));
      wait_pops(5, "t6_stream");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
